// File: rtl/prbs_loopback_checker.sv
// Loopback bit-error checker for a free-running PRBS generator.
// Holds the generator in reset, releases it, self-seeds an expected-sequence
// LFSR from the returned data, then compares TEST_LENGTH words.
// Ports:
//   clock, reset (async, active-high)
//   start, abort           run control
//   rx_word                returned prbs word, one per clock
//   gen_reset              drives the generator's reset
//   busy, done, pass       run status (registered)
//   lock_fail              seed capture saw an all-zero word
//   error_count            mismatched words this run (saturating)
//   words_checked          words compared this run
module prbs_loopback_checker #(
    parameter int WIDTH        = 128,
    parameter int TAP1         = 27,
    parameter int TAP2         = 30,
    parameter int RESET_CYCLES = 4,
    parameter int LOOP_LATENCY = 2,
    parameter int TEST_LENGTH  = 1024,
    parameter int CNT_WIDTH    = 32,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     rx_word,
    output logic                 gen_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 lock_fail,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [CNT_WIDTH-1:0] words_checked
);

    // SEED and WAIT share one phase counter sized for the longer of the two.
    localparam int PHASE_MAX = (RESET_CYCLES > LOOP_LATENCY + 1)
                               ? RESET_CYCLES : LOOP_LATENCY + 1;
    localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX + 1) : 1;

    localparam logic [PW-1:0]        SEED_LAST = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0]        WAIT_LAST = PW'(LOOP_LATENCY);
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(TEST_LENGTH - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state;
    logic [PW-1:0]        phase;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;
    logic [ERR_WIDTH-1:0] err_next;

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[TAP1] ^ x[TAP2]};
    endfunction

    always_comb begin
        mismatch = (rx_word != expected);
        err_next = error_count;
        if (mismatch && (error_count != ERR_MAX)) begin
            err_next = error_count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            phase         <= '0;
            expected      <= '0;
            gen_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            lock_fail     <= 1'b0;
            error_count   <= '0;
            words_checked <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    gen_reset <= 1'b1;
                    if (start && !abort) begin
                        state         <= S_SEED;
                        phase         <= '0;
                        busy          <= 1'b1;
                        error_count   <= '0;
                        words_checked <= '0;
                        lock_fail     <= 1'b0;
                    end
                end
                S_SEED: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        gen_reset <= 1'b1;
                    end else if (phase == SEED_LAST) begin
                        state     <= S_WAIT;
                        phase     <= '0;
                        gen_reset <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        gen_reset <= 1'b1;
                    end else if (phase == WAIT_LAST) begin
                        // An all-zero seed would lock the LFSR at zero.
                        if (rx_word == '0) begin
                            state     <= S_DONE;
                            lock_fail <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            gen_reset <= 1'b1;
                        end else begin
                            state    <= S_CHECK;
                            expected <= next_word(rx_word);
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        gen_reset <= 1'b1;
                    end else begin
                        expected      <= next_word(expected);
                        words_checked <= words_checked + 1'b1;
                        error_count   <= err_next;
                        if (words_checked == LAST_WORD) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_next == '0);
                            gen_reset <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    gen_reset <= 1'b1;
                    if (abort) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (start) begin
                        state         <= S_SEED;
                        phase         <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        error_count   <= '0;
                        words_checked <= '0;
                        lock_fail     <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    gen_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_loopback_checker.sv
// Bench for prbs_loopback_checker: generator model looped back through a
// 2-stage delay, with per-word corruption, scored by a sequence model.
module tb_prbs_loopback_checker;

    localparam int W       = 128;
    localparam int L       = 2;
    localparam int TL      = 16;
    localparam int RC      = 4;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  rx_word;
    logic          gen_reset;
    logic          busy;
    logic          done;
    logic          pass;
    logic          lock_fail;
    logic [EW-1:0] error_count;
    logic [31:0]   words_checked;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    prbs_loopback_checker #(
        .WIDTH(W), .TAP1(27), .TAP2(30), .RESET_CYCLES(RC),
        .LOOP_LATENCY(L), .TEST_LENGTH(TL), .CNT_WIDTH(32), .ERR_WIDTH(EW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .rx_word(rx_word),
        .gen_reset(gen_reset),
        .busy(busy),
        .done(done),
        .pass(pass),
        .lock_fail(lock_fail),
        .error_count(error_count),
        .words_checked(words_checked)
    );

    function automatic logic [W-1:0] nxt(input logic [W-1:0] x);
        return {x[W-2:0], x[27] ^ x[30]};
    endfunction

    // Generator model, loopback delay, corruption and capture.
    logic [W-1:0] g, d1, d2, gseed;
    logic         zero_rx;
    logic [W-1:0] mask [64];
    logic [W-1:0] q    [64];
    int           r = 0;

    always @(posedge clock) begin
        if (gen_reset) begin
            g <= gseed;
            r <= 0;
        end else begin
            g <= nxt(g);
            r <= r + 1;
        end
        d1 <= g;
        d2 <= d1;
    end

    always_comb begin
        rx_word = d2;
        if (!gen_reset && r < 64) rx_word = d2 ^ mask[r[5:0]];
        if (zero_rx) rx_word = '0;
    end

    always @(negedge clock) begin
        if (!gen_reset && r < 64) q[r[5:0]] <= rx_word;
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < 64; i++) begin
            mask[i] = '0;
            q[i]    = '0;
        end
        zero_rx = 1'b0;
        gseed   = {$urandom, $urandom, $urandom, $urandom} | W'(1);
    endtask

    // Sequence-level reference: seed from word L, then compare TL words
    // against successive LFSR steps from that seed.
    task automatic model(output bit lf, output int err, output int wc);
        logic [W-1:0] e;
        lf  = 1'b0;
        err = 0;
        wc  = 0;
        if (q[L] == '0) begin
            lf = 1'b1;
        end else begin
            e = nxt(q[L]);
            for (int k = 0; k < TL; k++) begin
                if (q[L + 1 + k] !== e && err < ERR_MAX) err++;
                e = nxt(e);
            end
            wc = TL;
        end
    endtask

    task automatic run_and_check(input string tag);
        int  hi;
        int  n;
        int  r_done;
        bit  lf;
        int  err;
        int  wc;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hi = 0;
        n  = 0;
        while (!done && n < 300) begin
            if (busy && gen_reset) hi++;
            @(negedge clock);
            n++;
        end
        r_done = r;
        chk({tag, "_done"}, W'(done), W'(1));
        model(lf, err, wc);
        chk({tag, "_rst_cycles"}, W'(hi), W'(RC));
        chk({tag, "_done_time"}, W'(r_done), W'(lf ? L + 1 : L + 1 + TL));
        chk({tag, "_lock"}, W'(lock_fail), W'(lf));
        chk({tag, "_errs"}, W'(error_count), W'(err));
        chk({tag, "_words"}, W'(words_checked), W'(wc));
        chk({tag, "_pass"}, W'(pass), W'(!lf && err == 0));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_genrst"}, W'(gen_reset), W'(1));
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (!(r == target && !gen_reset) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("wait_r", W'(r), W'(target));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        clear_env();
        #12;
        chk("rst_genrst", W'(gen_reset), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_pass", W'(pass), W'(0));
        chk("rst_lock", W'(lock_fail), W'(0));
        chk("rst_errs", W'(error_count), W'(0));
        chk("rst_words", W'(words_checked), W'(0));
        @(negedge clock);
        reset = 1'b0;

        clear_env();
        run_and_check("clean");
        chk("clean_pass1", W'(pass), W'(1));

        clear_env();
        mask[L + 1 + 4] = W'(1);
        run_and_check("flip5");
        chk("flip5_one", W'(error_count), W'(1));

        clear_env();
        zero_rx = 1'b1;
        run_and_check("zero");
        chk("zero_lock1", W'(lock_fail), W'(1));

        clear_env();
        for (int k = 0; k < TL; k++) mask[L + 1 + k] = '1;
        run_and_check("invert");
        chk("invert_sat", W'(error_count), W'(ERR_MAX));

        clear_env();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_r(L + 3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_genrst", W'(gen_reset), W'(1));
        chk("abort_done", W'(done), W'(0));
        chk("abort_words", W'(words_checked), W'(2));
        clear_env();
        run_and_check("rerun");
        chk("rerun_pass1", W'(pass), W'(1));

        for (int t = 0; t < 10; t++) begin
            clear_env();
            for (int k = L; k <= L + TL; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mask[k] = W'(1) << $urandom_range(0, W - 1);
                end
            end
            if ($urandom_range(0, 7) == 0) zero_rx = 1'b1;
            run_and_check("rand");
        end

        clear_env();
        for (int k = 0; k < TL; k++) mask[L + 1 + k] = '1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_r(L + 8);
        reset = 1'b1;
        #1;
        chk("arst_genrst", W'(gen_reset), W'(1));
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_errs", W'(error_count), W'(0));
        chk("arst_words", W'(words_checked), W'(0));
        chk("arst_done", W'(done), W'(0));
        @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("both_busy", W'(busy), W'(0));
        chk("both_genrst", W'(gen_reset), W'(1));
        @(negedge clock);
        chk("both_busy2", W'(busy), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
